// File: rtl/delay_alu_sched_pkg.sv
// Shared types, ALU opcode encoding and helpers for the late-ALU scheduler.
package delay_alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b01,
      SERVE1 = 2'b10
   } state_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  addr;
   } req_t;

   typedef struct packed {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_reg_info_t;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_ADDU = 5'd1;
   localparam logic [4:0] ALU_SUB  = 5'd2;
   localparam logic [4:0] ALU_SUBU = 5'd3;
   localparam logic [4:0] ALU_AND  = 5'd4;
   localparam logic [4:0] ALU_OR   = 5'd5;
   localparam logic [4:0] ALU_XOR  = 5'd6;
   localparam logic [4:0] ALU_NOR  = 5'd7;
   localparam logic [4:0] ALU_SLT  = 5'd8;
   localparam logic [4:0] ALU_SLTU = 5'd9;
   localparam logic [4:0] ALU_SLL  = 5'd10;
   localparam logic [4:0] ALU_SRL  = 5'd11;
   localparam logic [4:0] ALU_SRA  = 5'd12;
   localparam logic [4:0] ALU_LUI  = 5'd13;
   localparam logic [4:0] ALU_MOVN = 5'd14;
   localparam logic [4:0] ALU_MOVZ = 5'd15;
   localparam logic [4:0] ALU_CLO  = 5'd16;
   localparam logic [4:0] ALU_CLZ  = 5'd17;

   function automatic logic [5:0] clz32(input logic [31:0] v);
      logic [5:0] n;
      logic       found;
      n     = 6'd0;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (!found && !v[i]) n = n + 6'd1;
         else found = 1'b1;
      end
      return n;
   endfunction

   // Suppressed writes carry zero address/data so downstream never sees stale values.
   function automatic wr_reg_info_t mk_wb(input logic wr, input logic [4:0] addr,
                                          input logic [31:0] data);
      wr_reg_info_t w;
      if (wr) w = '{wr: 1'b1, addr: addr, data: data};
      else    w = '0;
      return w;
   endfunction

endpackage

// File: rtl/delay_alu_sched_alu.sv
// Late-stage ALU: MOVN/MOVZ write condition via wr_ctrl, overflow write-kill via ov_ctrl.
module delay_alu_sched_alu
   import delay_alu_sched_pkg::*;
#(
   parameter logic CTRL_CLO_CLZ = 1'b0
) (
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ov_ctrl,
   input  logic        wr_ctrl,
   output logic [31:0] result,
   output logic        write_reg
);

   logic [31:0] sum_s;
   logic [31:0] diff_s;
   logic        ovf_s;

   assign sum_s  = a + b;
   assign diff_s = a - b;

   // Result mux and signed-overflow detect
   always_comb begin
      result = 32'd0;
      ovf_s  = 1'b0;
      case (op)
         ALU_ADD:  begin result = sum_s;  ovf_s = (a[31] == b[31]) && (sum_s[31] != a[31]);  end
         ALU_ADDU: result = sum_s;
         ALU_SUB:  begin result = diff_s; ovf_s = (a[31] != b[31]) && (diff_s[31] != a[31]); end
         ALU_SUBU: result = diff_s;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'd0, a < b};
         ALU_SLL:  result = b << a[4:0];
         ALU_SRL:  result = b >> a[4:0];
         ALU_SRA:  result = $unsigned($signed(b) >>> a[4:0]);
         ALU_LUI:  result = {b[15:0], 16'd0};
         ALU_MOVN: result = a;
         ALU_MOVZ: result = a;
         ALU_CLO:  result = CTRL_CLO_CLZ ? {26'd0, clz32(~a)} : 32'd0;
         ALU_CLZ:  result = CTRL_CLO_CLZ ? {26'd0, clz32(a)} : 32'd0;
         default:  result = 32'd0;
      endcase
   end

   // Register-write qualifier
   always_comb begin
      if (wr_ctrl) begin
         if (op == ALU_MOVN)      write_reg = |b;
         else if (op == ALU_MOVZ) write_reg = ~|b;
         else                     write_reg = 1'b1;
      end else begin
         write_reg = !(ov_ctrl && ovf_s);
      end
   end

endmodule

// File: rtl/delay_alu_sched.sv
// Late-ALU scheduler: serialises dual-slot bundles onto one shared ALU.
// Optional: define DELAY_ALU_DUAL_EN for two ALUs and no serialisation.
module delay_alu_sched
   import delay_alu_sched_pkg::*;
#(
   parameter logic CTRL_CLO_CLZ = 1'b0,
   parameter int   CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  mem_allowin,
   input  logic [1:0]            req_valid,
   input  logic [1:0][4:0]       req_op,
   input  logic [1:0][31:0]      req_a,
   input  logic [1:0][31:0]      req_b,
   input  logic [1:0][4:0]       req_addr,
   output logic                  stall,
   output logic [1:0]            wb_valid,
   output logic [1:0][4:0]       wb_addr,
   output logic [1:0][31:0]      wb_data,
   output logic                  wb_done,
   output logic [CNT_W-1:0]      conflict_cnt
);

   req_t             req_s [2];
   logic [1:0][31:0] slot_res_s;
   logic [1:0]       slot_wr_s;
   state_t           state_r, state_nxt_s;
   wr_reg_info_t     park_r, park_nxt_s;
   logic [1:0]       wb_valid_nxt_s;
   logic [1:0][4:0]  wb_addr_nxt_s;
   logic [1:0][31:0] wb_data_nxt_s;
   logic             wb_done_nxt_s;
   logic             cnt_inc_s;

   assign req_s[0] = '{valid: req_valid[0], op: req_op[0], a: req_a[0], b: req_b[0], addr: req_addr[0]};
   assign req_s[1] = '{valid: req_valid[1], op: req_op[1], a: req_a[1], b: req_b[1], addr: req_addr[1]};

`ifdef DELAY_ALU_DUAL_EN
   localparam bit DUAL_EN = 1'b1;

   for (genvar g = 0; g < 2; g++) begin : g_alu
      delay_alu_sched_alu #(.CTRL_CLO_CLZ(CTRL_CLO_CLZ)) u_alu (
         .op        (req_s[g].op),
         .a         (req_s[g].a),
         .b         (req_s[g].b),
         .ov_ctrl   (1'b0),
         .wr_ctrl   ((req_s[g].op == ALU_MOVN) || (req_s[g].op == ALU_MOVZ)),
         .result    (slot_res_s[g]),
         .write_reg (slot_wr_s[g])
      );
   end
`else
   localparam bit DUAL_EN = 1'b0;
   logic        sel_s;
   logic [31:0] alu_res_s;
   logic        alu_wr_s;

   // Slot 1 owns the ALU in SERVE1 or when it is the only requester
   assign sel_s = (state_r == SERVE1) || (req_valid == 2'b10);

   delay_alu_sched_alu #(.CTRL_CLO_CLZ(CTRL_CLO_CLZ)) u_alu (
      .op        (req_s[sel_s].op),
      .a         (req_s[sel_s].a),
      .b         (req_s[sel_s].b),
      .ov_ctrl   (1'b0),
      .wr_ctrl   ((req_s[sel_s].op == ALU_MOVN) || (req_s[sel_s].op == ALU_MOVZ)),
      .result    (alu_res_s),
      .write_reg (alu_wr_s)
   );

   assign slot_res_s = {2{alu_res_s}};
   assign slot_wr_s  = {2{alu_wr_s}};
`endif

   // Next-state, park update, writeback staging and stall
   always_comb begin
      state_nxt_s    = state_r;
      park_nxt_s     = park_r;
      wb_valid_nxt_s = 2'b00;
      wb_addr_nxt_s  = '0;
      wb_data_nxt_s  = '0;
      wb_done_nxt_s  = 1'b0;
      cnt_inc_s      = 1'b0;
      stall          = 1'b0;
      if (flush) begin
         state_nxt_s = IDLE;
         park_nxt_s  = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (mem_allowin && (|req_valid)) begin
                  if (!DUAL_EN && (&req_valid)) begin
                     stall       = 1'b1;
                     cnt_inc_s   = 1'b1;
                     park_nxt_s  = mk_wb(slot_wr_s[0], req_s[0].addr, slot_res_s[0]);
                     state_nxt_s = SERVE1;
                  end else begin
                     for (int i = 0; i < 2; i++) begin
                        if (req_s[i].valid && slot_wr_s[i]) begin
                           wb_valid_nxt_s[i] = 1'b1;
                           wb_addr_nxt_s[i]  = req_s[i].addr;
                           wb_data_nxt_s[i]  = slot_res_s[i];
                        end else begin
                           wb_valid_nxt_s[i] = 1'b0;
                        end
                     end
                     wb_done_nxt_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            SERVE1: begin
               if (mem_allowin) begin
                  wb_valid_nxt_s = {slot_wr_s[1], park_r.wr};
                  wb_addr_nxt_s  = {slot_wr_s[1] ? req_s[1].addr : 5'd0, park_r.addr};
                  wb_data_nxt_s  = {slot_wr_s[1] ? slot_res_s[1] : 32'd0, park_r.data};
                  wb_done_nxt_s  = 1'b1;
                  park_nxt_s     = '0;
                  state_nxt_s    = IDLE;
               end else begin
                  stall = 1'b1;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               park_nxt_s  = '0;
            end
         endcase
      end
   end

   // State, park, writeback and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         park_r       <= '0;
         wb_valid     <= 2'b00;
         wb_addr      <= '0;
         wb_data      <= '0;
         wb_done      <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         state_r  <= state_nxt_s;
         park_r   <= park_nxt_s;
         wb_valid <= wb_valid_nxt_s;
         wb_addr  <= wb_addr_nxt_s;
         wb_data  <= wb_data_nxt_s;
         wb_done  <= wb_done_nxt_s;
         if (cnt_inc_s) conflict_cnt <= conflict_cnt + CNT_W'(1'b1);
      end
   end

endmodule

// File: tb/tb_delay_alu_sched.sv
// Directed bench for delay_alu_sched: vector table of single bundles plus dual/stall/flush/reset sequences.
module tb_delay_alu_sched;
   import delay_alu_sched_pkg::*;

   logic             clk = 1'b0;
   logic             rst, flush, mem_allowin;
   logic [1:0]       req_valid;
   logic [1:0][4:0]  req_op;
   logic [1:0][31:0] req_a, req_b;
   logic [1:0][4:0]  req_addr;
   logic             stall, wb_done;
   logic [1:0]       wb_valid;
   logic [1:0][4:0]  wb_addr;
   logic [1:0][31:0] wb_data;
   logic [31:0]      conflict_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   delay_alu_sched #(.CTRL_CLO_CLZ(1'b0), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .mem_allowin(mem_allowin),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_addr(req_addr), .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_done(wb_done), .conflict_cnt(conflict_cnt)
   );

   typedef struct {
      logic [1:0]  v;
      logic [4:0]  op0; logic [31:0] a0; logic [31:0] b0; logic [4:0] d0;
      logic [4:0]  op1; logic [31:0] a1; logic [31:0] b1; logic [4:0] d1;
      logic [1:0]  ev;
      logic [9:0]  eaddr;
      logic [63:0] edata;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v,
                        input logic [4:0] o0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] d0,
                        input logic [4:0] o1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] d1);
      req_valid = v;
      req_op    = {o1, o0};
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      req_addr  = {d1, d0};
   endtask

   task automatic chk_wb(input string nm, input logic [1:0] ev, input logic [9:0] ea,
                         input logic [63:0] ed, input logic ed_done);
      chk({nm, "_valid"}, 64'(wb_valid), 64'(ev));
      chk({nm, "_addr"},  64'(wb_addr),  64'(ea));
      chk({nm, "_data"},  64'(wb_data),  ed);
      chk({nm, "_done"},  64'(wb_done),  64'(ed_done));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{2'b01, ALU_ADDU, 32'd5, 32'd7, 5'd3, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd3}, {32'd0, 32'd12}};
      vecs[1]  = '{2'b10, ALU_ADDU, 32'd0, 32'd0, 5'd0, ALU_SUBU, 32'd10, 32'd3, 5'd5,
                  2'b10, {5'd5, 5'd0}, {32'd7, 32'd0}};
      vecs[2]  = '{2'b01, ALU_MOVN, 32'h55, 32'd0, 5'd7, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b00, 10'd0, 64'd0};
      vecs[3]  = '{2'b10, ALU_ADDU, 32'd0, 32'd0, 5'd0, ALU_MOVN, 32'h55, 32'd2, 5'd8,
                  2'b10, {5'd8, 5'd0}, {32'h55, 32'd0}};
      vecs[4]  = '{2'b01, ALU_AND, 32'h0000F0F0, 32'h0000FF00, 5'd1, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd1}, {32'd0, 32'h0000F000}};
      vecs[5]  = '{2'b01, ALU_SLL, 32'd4, 32'd1, 5'd2, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd2}, {32'd0, 32'd16}};
      vecs[6]  = '{2'b01, ALU_SRA, 32'd4, 32'h80000000, 5'd2, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd2}, {32'd0, 32'hF8000000}};
      vecs[7]  = '{2'b01, ALU_SLTU, 32'd1, 32'hFFFFFFFF, 5'd9, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd9}, {32'd0, 32'd1}};
      vecs[8]  = '{2'b01, ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd10, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd10}, {32'd0, 32'h80000000}};
      vecs[9]  = '{2'b01, ALU_CLZ, 32'h0000FFFF, 32'd0, 5'd11, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd11}, 64'd0};
      vecs[10] = '{2'b10, ALU_ADDU, 32'd0, 32'd0, 5'd0, ALU_NOR, 32'd0, 32'd0, 5'd12,
                  2'b10, {5'd12, 5'd0}, {32'hFFFFFFFF, 32'd0}};
      vecs[11] = '{2'b01, ALU_MOVZ, 32'd9, 32'd0, 5'd13, ALU_ADDU, 32'd0, 32'd0, 5'd0,
                  2'b01, {5'd0, 5'd13}, {32'd0, 32'd9}};

      rst = 1'b1; flush = 1'b0; mem_allowin = 1'b1;
      drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
      repeat (3) tick();
      chk_wb("reset", 2'b00, 10'd0, 64'd0, 1'b0);
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_cnt", 64'(conflict_cnt), 64'd0);
      rst = 1'b0;

      // Back-to-back single bundles, one per cycle
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].v, vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].d0,
               vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].d1);
         #1 chk($sformatf("vec%0d_stall", i), 64'(stall), 64'd0);
         tick();
         chk_wb($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eaddr, vecs[i].edata, 1'b1);
      end
      req_valid = 2'b00;
      tick();
      chk_wb("idle", 2'b00, 10'd0, 64'd0, 1'b0);

      // Held in IDLE: no accept while mem_allowin is low
      mem_allowin = 1'b0;
      drive(2'b11, ALU_ADDU, 32'd1, 32'd1, 5'd1, ALU_ADDU, 32'd2, 32'd2, 5'd2);
      #1 chk("noallow_stall", 64'(stall), 64'd0);
      tick();
      chk_wb("noallow", 2'b00, 10'd0, 64'd0, 1'b0);
      chk("noallow_cnt", 64'(conflict_cnt), 64'd0);
      req_valid = 2'b00;
      mem_allowin = 1'b1;
      tick();

`ifdef DELAY_ALU_DUAL_EN
      drive(2'b11, ALU_ADDU, 32'd1, 32'd2, 5'd4, ALU_SUBU, 32'd10, 32'd3, 5'd5);
      #1 chk("dualen_stall", 64'(stall), 64'd0);
      tick();
      req_valid = 2'b00;
      chk_wb("dualen", 2'b11, {5'd5, 5'd4}, {32'd7, 32'd3}, 1'b1);
      chk("dualen_cnt", 64'(conflict_cnt), 64'd0);
`else
      // Dual bundle: stall only in the acceptance cycle, results at t+2
      drive(2'b11, ALU_ADDU, 32'd1, 32'd2, 5'd4, ALU_SUBU, 32'd10, 32'd3, 5'd5);
      #1 chk("dualA_stall_t", 64'(stall), 64'd1);
      tick();
      exp_cnt++;
      chk("dualA_stall_t1", 64'(stall), 64'd0);
      chk("dualA_done_t1", 64'(wb_done), 64'd0);
      chk("dualA_cnt", 64'(conflict_cnt), 64'(exp_cnt));
      tick();
      req_valid = 2'b00;
      chk_wb("dualA", 2'b11, {5'd5, 5'd4}, {32'd7, 32'd3}, 1'b1);

      // Slot 1 MOVZ with nonzero b: only slot 0 writes
      drive(2'b11, ALU_ADDU, 32'd20, 32'd22, 5'd9, ALU_MOVZ, 32'h77, 32'd1, 5'd10);
      tick();
      exp_cnt++;
      tick();
      req_valid = 2'b00;
      chk_wb("dualB", 2'b01, {5'd0, 5'd9}, {32'd0, 32'd42}, 1'b1);

      // mem_allowin low for 3 cycles in SERVE1
      drive(2'b11, ALU_ADDU, 32'd100, 32'd1, 5'd11, ALU_ADDU, 32'd200, 32'd2, 5'd12);
      tick();
      exp_cnt++;
      for (int k = 0; k < 3; k++) begin
         mem_allowin = 1'b0;
         #1 chk($sformatf("hold%0d_stall", k), 64'(stall), 64'd1);
         chk($sformatf("hold%0d_done", k), 64'(wb_done), 64'd0);
         tick();
      end
      mem_allowin = 1'b1;
      #1 chk("hold_release_stall", 64'(stall), 64'd0);
      tick();
      req_valid = 2'b00;
      chk_wb("dualC", 2'b11, {5'd12, 5'd11}, {32'd202, 32'd101}, 1'b1);
      tick();
      chk("dualC_pulse", 64'(wb_done), 64'd0);
      chk("dualC_cnt", 64'(conflict_cnt), 64'(exp_cnt));

      // Flush in SERVE1, then a single bundle completes at +1
      drive(2'b11, ALU_SUBU, 32'd9, 32'd4, 5'd13, ALU_ADDU, 32'd1, 32'd1, 5'd14);
      tick();
      exp_cnt++;
      flush = 1'b1;
      #1 chk("flush_stall", 64'(stall), 64'd0);
      tick();
      flush = 1'b0;
      chk_wb("flush", 2'b00, 10'd0, 64'd0, 1'b0);
      drive(2'b01, ALU_ADDU, 32'd2, 32'd2, 5'd6, ALU_ADDU, 32'd0, 32'd0, 5'd0);
      #1 chk("postflush_stall", 64'(stall), 64'd0);
      tick();
      req_valid = 2'b00;
      chk_wb("postflush", 2'b01, {5'd0, 5'd6}, {32'd0, 32'd4}, 1'b1);
      chk("postflush_cnt", 64'(conflict_cnt), 64'(exp_cnt));

      // Reset mid-SERVE1
      drive(2'b11, ALU_ADDU, 32'd3, 32'd3, 5'd15, ALU_ADDU, 32'd4, 32'd4, 5'd16);
      tick();
      rst = 1'b1;
      req_valid = 2'b00;
      tick();
      rst = 1'b0;
      chk_wb("midrst", 2'b00, 10'd0, 64'd0, 1'b0);
      chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
      chk("midrst_stall", 64'(stall), 64'd0);
      tick();
      chk("midrst_after", 64'(wb_done), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
